// File: rtl/matrix_dump_reader_pkg.sv
// Shared definitions for the data-memory side blocks: widths, row stride,
// dump FSM state encoding.
package matrix_dump_reader_pkg;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DATA_W     = 12;
  localparam int DEF_DIM_W      = 5;
  localparam int DEF_ROW_STRIDE = 64;
  localparam int BYTE_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LAT,
    ST_HI,
    ST_LO,
    ST_DONE
  } dump_state_e;
endpackage

// File: rtl/matrix_dump_reader_addr_gen.sv
// Row/column walker for the dump: keeps the current row base incrementally
// and presents a registered read address.
module dump_addr_gen
  import matrix_dump_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DIM_W      = DEF_DIM_W,
  parameter int ROW_STRIDE = DEF_ROW_STRIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  dim,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              last
);
  logic [DIM_W-1:0]  dim_q, dim_d, row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic [DIM_W-1:0]  dim_m1;
  logic              row_end;

  assign dim_m1   = dim_q - 1'b1;
  assign row_end  = (col_q == dim_m1);
  assign last     = row_end && (row_q == dim_m1);
  assign mem_addr = addr_q;

  always_comb begin
    dim_d      = dim_q;
    row_d      = row_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (init) begin
      dim_d      = dim;
      row_d      = '0;
      col_d      = '0;
      row_base_d = base_addr;
      addr_d     = base_addr;
    end else if (advance && !last) begin
      if (row_end) begin
        // row base steps by the stride; wraps modulo 2^ADDR_W silently
        row_d      = row_q + 1'b1;
        col_d      = '0;
        row_base_d = row_base_q + ADDR_W'(ROW_STRIDE);
        addr_d     = row_base_d;
      end else begin
        col_d  = col_q + 1'b1;
        addr_d = row_base_q + ADDR_W'(col_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dim_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      dim_q      <= dim_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end
endmodule

// File: rtl/matrix_dump_reader.sv
// Dumps an n x n region of the data memory as a byte stream, high nibble
// byte first, one memory word per four cycles when the sink never stalls.
module matrix_dump_reader
  import matrix_dump_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ROW_STRIDE = DEF_ROW_STRIDE,
  parameter int DIM_W      = DEF_DIM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  dim,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);
  dump_state_e       state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              done_q, done_d;
  logic              ag_init, ag_advance, ag_last;

  dump_addr_gen #(
    .ADDR_W     (ADDR_W),
    .DIM_W      (DIM_W),
    .ROW_STRIDE (ROW_STRIDE)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .init      (ag_init),
    .advance   (ag_advance),
    .base_addr (base_addr),
    .dim       (dim),
    .mem_addr  (mem_addr),
    .last      (ag_last)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    done_d     = 1'b0;
    ag_init    = 1'b0;
    ag_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dim != '0) begin
            ag_init = 1'b1;
            state_d = ST_RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RD:  state_d = ST_LAT;
      ST_LAT: begin
        word_d  = mem_dataout;
        state_d = ST_HI;
      end
      ST_HI: if (tx_ready) state_d = ST_LO;
      ST_LO: begin
        if (tx_ready) begin
          if (ag_last) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            ag_advance = 1'b1;
            state_d    = ST_RD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_data = '0;
    if (state_q == ST_HI)      tx_data = BYTE_W'(word_q[DATA_W-1:BYTE_W]);
    else if (state_q == ST_LO) tx_data = word_q[BYTE_W-1:0];
  end

  assign tx_valid = (state_q == ST_HI) || (state_q == ST_LO);
  assign busy     = state_q inside {ST_RD, ST_LAT, ST_HI, ST_LO};
  assign mem_req  = busy;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_matrix_dump_reader.sv
// Directed + randomized bench for matrix_dump_reader against a row-major
// reference of the dumped region.
module tb_matrix_dump_reader;
  logic        clk = 1'b0;
  logic        rst, start, tx_ready;
  logic [11:0] base_addr;
  logic [4:0]  dim;
  logic        mem_req, tx_valid, busy, done;
  logic [11:0] mem_addr, mem_dataout;
  logic [7:0]  tx_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] ram [4096];
  logic [7:0]  got_b[$];
  logic [11:0] got_a[$];

  matrix_dump_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .dim         (dim),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_dataout (mem_dataout),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // synchronous-read memory: data appears the cycle after the address edge
  always @(posedge clk) mem_dataout <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // byte-stream monitor: records handshakes, checks stall stability
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [11:0] prev_addr;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(tx_valid), 32'd1);
          chk("hold_data", 32'(tx_data), 32'(prev_data));
          chk("hold_addr", 32'(mem_addr), 32'(prev_addr));
        end
        if (tx_valid && tx_ready) begin
          got_b.push_back(tx_data);
          got_a.push_back(mem_addr);
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_addr  = mem_addr;
      end
    end
  end

  // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles at first HI
  task automatic run_dump(input logic [11:0] b, input int n, input int mode, input bit poke);
    logic [11:0] exp_a[$];
    logic [7:0]  exp_b[$];
    logic [11:0] a, w;
    int cyc, stall_cnt, budget, lim;
    bit seen;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        a = 12'((int'(b) + r * 64 + c) % 4096);
        w = ram[a];
        exp_a.push_back(a);
        exp_b.push_back({4'h0, w[11:8]});
        exp_b.push_back(w[7:0]);
      end
    got_b.delete();
    got_a.delete();
    tx_ready  = 1'b1;
    base_addr = b;
    dim       = 5'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_req", 32'(mem_req), 32'd1);
    chk("start_addr", 32'(mem_addr), 32'(b));
    cyc = 1; stall_cnt = 0; seen = 0;
    budget = 8 * n * n + 50;
    while (!seen && cyc < budget) begin
      if (done) begin
        seen = 1;
      end else begin
        case (mode)
          1: tx_ready = ($urandom_range(0, 3) != 0);
          2: if (tx_valid && stall_cnt < 5) begin tx_ready = 1'b0; stall_cnt++; end
             else tx_ready = 1'b1;
          default: tx_ready = 1'b1;
        endcase
        start = poke && (cyc == 3 || cyc == 10 || cyc == 20);
        if (start) begin
          base_addr = 12'($urandom);
          dim       = 5'($urandom);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_req", 32'(mem_req), 32'd0);
    chk("done_valid", 32'(tx_valid), 32'd0);
    if (mode == 0) chk("dump_cycles", 32'(cyc), 32'(4 * n * n + 1));
    if (mode == 2) chk("dump_cycles_stall", 32'(cyc), 32'(4 * n * n + 6));
    chk("nbytes", 32'(got_b.size()), 32'(2 * n * n));
    lim = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < lim; i++) begin
      chk($sformatf("byte%0d", i), 32'(got_b[i]), 32'(exp_b[i]));
      chk($sformatf("addr%0d", i), 32'(got_a[i]), 32'(exp_a[i / 2]));
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int lim;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1; base_addr = '0; dim = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 12'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic 4x4 dump
    ram[4] = 12'd1; ram[5] = 12'd2; ram[6] = 12'd3; ram[7] = 12'd4;
    run_dump(12'd4, 4, 0, 0);
    if (got_b.size() >= 10) begin
      chk("a_b0", 32'(got_b[0]), 32'h00); chk("a_b1", 32'(got_b[1]), 32'h01);
      chk("a_b3", 32'(got_b[3]), 32'h02); chk("a_b7", 32'(got_b[7]), 32'h04);
      chk("a_row1", 32'(got_a[8]), 32'd68);
    end

    // dim = 0: immediate done, no reads, no bytes
    dim = '0; base_addr = 12'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("z_done", 32'(done), 32'd1);
    chk("z_req", 32'(mem_req), 32'd0);
    chk("z_valid", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    chk("z_done_drop", 32'(done), 32'd0);
    chk("z_req2", 32'(mem_req), 32'd0);

    // address wrap
    ram[4094] = 12'hABC;
    run_dump(12'd4094, 2, 0, 0);
    if (got_b.size() >= 6) begin
      chk("w_b0", 32'(got_b[0]), 32'h0A); chk("w_b1", 32'(got_b[1]), 32'hBC);
      chk("w_a2", 32'(got_a[2]), 32'd4095); chk("w_a4", 32'(got_a[4]), 32'd62);
    end

    run_dump(12'($urandom), 3, 2, 0);     // 5-cycle stall in first HI
    run_dump(12'd100, 3, 0, 1);           // start pulses while busy

    // sync reset during LO of element 3
    base_addr = 12'd200; dim = 5'd3; tx_ready = 1'b1; start = 1'b1;
    got_b.delete(); got_a.delete();
    @(posedge clk); #1;
    start = 1'b0;
    lim = 0;
    while (!(got_b.size() == 7 && tx_valid) && lim < 200) begin
      @(posedge clk); #1;
      lim++;
    end
    chk("rst_reach_lo", 32'(lim < 200), 32'd1);
    rst = 1'b1; tx_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(tx_valid), 32'd0);
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_dump(12'd200, 3, 1, 0);

    for (int k = 0; k < 4; k++)
      run_dump(12'($urandom), int'($urandom_range(1, 6)), 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
